// File: rtl/pcap_replay_pkg.sv
// Shared types for the pcap replay sequencer: FSM state encoding and credit-counter width helper.
package pcap_replay_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter must be able to hold the full credit value NUM_CREDITS itself.
   function automatic int credit_width(input int num_credits);
      return $clog2(num_credits + 1);
   endfunction

endpackage

// File: rtl/pcap_replay_credit_ctr.sv
// Credit counter for the downstream burst buffer: debits on request handshake, credits on
// burst_consumed, saturates at full and raises a sticky error on an unexpected return.
module pcap_replay_credit_ctr
   import pcap_replay_pkg::*;
#(
   parameter int NUM_CREDITS = 16,
   parameter int CW          = credit_width(NUM_CREDITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sw_rst,
   input  logic          take,
   input  logic          give,
   output logic [CW-1:0] credits,
   output logic          full,
   output logic          credit_err
);

   localparam logic [CW-1:0] FULL_C = CW'(NUM_CREDITS);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   assign full = (credits == FULL_C);

   // A simultaneous take and give cancel out, so only the lone cases move the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits    <= FULL_C;
         credit_err <= 1'b0;
      end else if (sw_rst) begin
         credits    <= FULL_C;
         credit_err <= 1'b0;
      end else if (take && !give) begin
         credits <= credits - ONE_C;
      end else if (give && !take) begin
         if (full) begin
            credit_err <= 1'b1;
         end else begin
            credits <= credits + ONE_C;
         end
      end
   end

endmodule

// File: rtl/pcap_replay_seq.sv
// PCAP replay sequencer: walks QDR burst addresses 0..mem_addr_high for a number of passes under
// credit flow control. Optional issued_bursts counter enabled by PCAP_REPLAY_SEQ_STATS_EN.
module pcap_replay_seq
   import pcap_replay_pkg::*;
#(
   parameter int QDR_ADDR_WIDTH     = 19,
   parameter int REPLAY_COUNT_WIDTH = 32,
   parameter int NUM_CREDITS        = 16
) (
   input  logic                          axi_aclk,
   input  logic                          axi_areset,
   input  logic                          sw_rst,
   input  logic                          start_replay,
   input  logic [QDR_ADDR_WIDTH-1:0]     mem_addr_high,
   input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
   output logic                          rd_req_valid,
   input  logic                          rd_req_ready,
   output logic [QDR_ADDR_WIDTH-1:0]     rd_req_addr,
   output logic                          rd_req_last,
   input  logic                          burst_consumed,
   output logic                          busy,
   output logic                          done,
   output logic [REPLAY_COUNT_WIDTH-1:0] pass_cnt,
`ifdef PCAP_REPLAY_SEQ_STATS_EN
   output logic [31:0]                   issued_bursts,
`endif
   output logic                          credit_err
);

   localparam int CW = credit_width(NUM_CREDITS);
   localparam logic [QDR_ADDR_WIDTH-1:0]     ADDR_ONE = QDR_ADDR_WIDTH'(1);
   localparam logic [REPLAY_COUNT_WIDTH-1:0] PASS_ONE = REPLAY_COUNT_WIDTH'(1);

   state_t                          state;
   state_t                          state_nx;
   logic [QDR_ADDR_WIDTH-1:0]       addr;
   logic [QDR_ADDR_WIDTH-1:0]       high_lat;
   logic [REPLAY_COUNT_WIDTH-1:0]   count_lat;
   logic                            start_d;
   logic [CW-1:0]                   credits;
   logic                            credits_full;
   logic                            rise;
   logic                            hs;
   logic                            wrap;
   logic                            final_pass;

   assign rise         = start_replay & ~start_d;
   assign rd_req_valid = (state == ISSUE) && (credits != '0);
   assign hs           = rd_req_valid & rd_req_ready;
   assign wrap         = (addr == high_lat);
   assign rd_req_addr  = addr;
   assign rd_req_last  = rd_req_valid & wrap;
   assign final_pass   = hs && wrap && (count_lat != '0) && ((pass_cnt + PASS_ONE) == count_lat);
   assign busy         = (state == ISSUE) || (state == DRAIN);
   assign done         = (state == DONE);

   pcap_replay_credit_ctr #(
      .NUM_CREDITS (NUM_CREDITS),
      .CW          (CW)
   ) u_credit (
      .clk        (axi_aclk),
      .rst        (axi_areset),
      .sw_rst     (sw_rst),
      .take       (hs),
      .give       (burst_consumed),
      .credits    (credits),
      .full       (credits_full),
      .credit_err (credit_err)
   );

   // A stop with a request on the bus waits for its handshake so valid never retracts.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (rise) state_nx = ISSUE;
         ISSUE: begin
            if (final_pass) begin
               state_nx = DRAIN;
            end else if (!start_replay && (hs || !rd_req_valid)) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: if (credits_full) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // start_d comes out of hard reset high so a level held through reset is not taken as an edge.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state     <= IDLE;
         addr      <= '0;
         pass_cnt  <= '0;
         high_lat  <= '0;
         count_lat <= '0;
         start_d   <= 1'b1;
      end else if (sw_rst) begin
         state     <= IDLE;
         addr      <= '0;
         pass_cnt  <= '0;
         high_lat  <= '0;
         count_lat <= '0;
         start_d   <= start_replay;
      end else begin
         state   <= state_nx;
         start_d <= start_replay;
         if ((state == IDLE) && rise) begin
            high_lat  <= mem_addr_high;
            count_lat <= replay_count;
            addr      <= '0;
            pass_cnt  <= '0;
         end else if (hs) begin
            if (wrap) begin
               addr     <= '0;
               pass_cnt <= pass_cnt + PASS_ONE;
            end else begin
               addr <= addr + ADDR_ONE;
            end
         end
      end
   end

`ifdef PCAP_REPLAY_SEQ_STATS_EN
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         issued_bursts <= '0;
      end else if (sw_rst) begin
         issued_bursts <= '0;
      end else if (hs) begin
         issued_bursts <= issued_bursts + 32'd1;
      end
   end
`endif

endmodule

// File: doc/pcap_replay_seq.md
PCAP_REPLAY_SEQ -- requirements
Module: pcap_replay_seq

Interface
REQ-001 SHALL have parameter QDR_ADDR_WIDTH, default 19: width of the QDR burst address.
REQ-002 SHALL have parameter REPLAY_COUNT_WIDTH, default 32: width of the pass counter.
REQ-003 SHALL have parameter NUM_CREDITS, default 16: downstream burst-buffer depth, range 1..255.
REQ-004 SHALL have port axi_aclk, input, 1 bit: the only clock.
REQ-005 SHALL have port axi_areset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port sw_rst, input, 1 bit: synchronous soft reset, level-sensitive.
REQ-007 SHALL have port start_replay, input, 1 bit: run request; a rising edge starts a run and a low level requests a stop.
REQ-008 SHALL have port mem_addr_high, input, QDR_ADDR_WIDTH bits: last burst address of the stored trace (inclusive).
REQ-009 SHALL have port replay_count, input, REPLAY_COUNT_WIDTH bits: number of passes; 0 = continuous.
REQ-010 SHALL have ports rd_req_valid (output, 1), rd_req_ready (input, 1), rd_req_addr (output, QDR_ADDR_WIDTH) and rd_req_last (output, 1): the QDR burst read request channel; rd_req_last marks the final burst of a pass.
REQ-011 SHALL have port burst_consumed, input, 1 bit: one-cycle pulse per burst drained from the downstream buffer (credit return).
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), pass_cnt (output, REPLAY_COUNT_WIDTH) and credit_err (output, 1, sticky).

Function
REQ-013 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-014 SHALL transition IDLE->ISSUE one cycle after a start_replay rising edge, latching mem_addr_high and replay_count, clearing addr and pass_cnt, and ignoring later input changes until the next run.
REQ-015 SHALL drive rd_req_valid high in ISSUE only while credits>0; a handshake occurs when rd_req_valid and rd_req_ready are both high.
REQ-016 SHALL hold rd_req_addr and rd_req_last stable while rd_req_valid is high and rd_req_ready is low; once asserted, valid SHALL not drop without a handshake.
REQ-017 SHALL, on each handshake, increment addr; when addr==latched high it SHALL wrap addr to 0 and increment pass_cnt, and rd_req_last SHALL be high for that burst.
REQ-018 SHALL, when latched replay_count!=0 and the wrapping handshake makes pass_cnt equal replay_count, go ISSUE->DRAIN without issuing further requests.
REQ-019 SHALL treat start_replay low in ISSUE as a stop: the pending handshake completes first, then the block goes to DRAIN.
REQ-020 SHALL keep the credit counter with reset value NUM_CREDITS: -1 per handshake, +1 per burst_consumed, unchanged when both occur in the same cycle.
REQ-021 SHALL, on burst_consumed while credits==NUM_CREDITS, saturate the counter and set credit_err until reset or sw_rst.
REQ-022 SHALL go DRAIN->DONE when credits==NUM_CREDITS; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-023 SHALL drive busy high in ISSUE and DRAIN.
REQ-024 SHALL give a latency of 1 cycle from a handshake to the next valid request when credits remain.
REQ-025 SHALL, with mem_addr_high==0, issue addr 0 with rd_req_last high on every burst.
REQ-026 SHALL ignore start_replay edges outside IDLE.
REQ-027 SHALL wrap pass_cnt modulo 2^REPLAY_COUNT_WIDTH in continuous mode.

Reset
REQ-028 SHALL, on axi_areset (asynchronous) or sw_rst (synchronous), set state=IDLE, addr=0, pass_cnt=0, credits=NUM_CREDITS, and rd_req_valid, rd_req_last, busy, done and credit_err to 0.
REQ-029 SHALL, when reset occurs mid-run, abandon the run immediately with no done pulse; outstanding credits are assumed returned.

Configuration
REQ-030 SHALL, when PCAP_REPLAY_SEQ_STATS_EN is defined, add output issued_bursts (32 bits, wraps) counting handshakes since the last reset; it is cleared by reset and sw_rst only, not at run start.
REQ-031 SHALL, without PCAP_REPLAY_SEQ_STATS_EN, omit the port and its counter logic.

Structure
REQ-032 SHALL take the state enum and the credit-width constant ($clog2(NUM_CREDITS+1)) from shared package pcap_replay_pkg.
REQ-033 SHALL implement the credit counter and credit_err logic in sub-module pcap_replay_credit_ctr.

Verification
REQ-034 Bench SHALL cover: mem_addr_high=3, replay_count=2, ready always high, instant credit return -> addrs 0,1,2,3,0,1,2,3, rd_req_last on both 3s, pass_cnt=2, one done pulse.
REQ-035 Bench SHALL cover: NUM_CREDITS=4, burst_consumed never asserted -> exactly 4 handshakes, then valid low; one consumed pulse -> exactly one more request.
REQ-036 Bench SHALL cover: rd_req_ready held low 5 cycles with valid high -> addr and last stable, valid never drops.
REQ-037 Bench SHALL cover: replay_count=0, start_replay dropped after 10 handshakes -> no new requests, DRAIN until credits=NUM_CREDITS, then done.
REQ-038 Bench SHALL cover: burst_consumed together with a handshake -> credits unchanged; consumed at full -> credit_err=1 and credits=NUM_CREDITS.
REQ-039 Bench SHALL cover: axi_areset asserted in ISSUE -> all outputs 0 in the same cycle, state IDLE, no done pulse.
